// File: rtl/e203_exu_wbck_rr.sv
`default_nettype none
// ============================================================================
// Module   : e203_exu_wbck_rr
// Function : Write-back arbiter: round-robin long-pipe channels over the ALU,
//            with an ALU starvation override and integer/FP port routing.
// Revision : 1.0
// ============================================================================
module e203_exu_wbck_rr #(
  parameter int LP_CHNL    = 2,
  parameter int STARVE_MAX = 4,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_wbck_i_valid,
  output logic                  alu_wbck_i_ready,
  input  logic [31:0]           alu_wbck_i_wdat,
  input  logic [4:0]            alu_wbck_i_rdidx,
  input  logic [LP_CHNL-1:0]    longp_wbck_i_valid,
  output logic [LP_CHNL-1:0]    longp_wbck_i_ready,
  input  logic [32*LP_CHNL-1:0] longp_wbck_i_wdat,
  input  logic [5*LP_CHNL-1:0]  longp_wbck_i_rdidx,
  input  logic [5*LP_CHNL-1:0]  longp_wbck_i_flags,
  input  logic [LP_CHNL-1:0]    longp_wbck_i_rdfpu,
  output logic                  rf_wbck_o_ena,
  output logic [31:0]           rf_wbck_o_wdat,
  output logic [4:0]            rf_wbck_o_rdidx,
  output logic                  frf_wbck_o_ena,
  output logic [31:0]           frf_wbck_o_wdat,
  output logic [4:0]            frf_wbck_o_rdidx,
  output logic [4:0]            frf_wbck_o_flags
);

  localparam int            PW           = (LP_CHNL > 1) ? $clog2(LP_CHNL) : 1;
  localparam int            SW           = 4;
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_lp_sel;
  logic [SW-1:0] r_starve_cnt;
  logic          w_lp_any;
  logic          w_starve;
  logic          w_lp_win;
  logic          w_alu_gnt;
  logic [31:0]   w_lp_wdat;
  logic [4:0]    w_lp_rdidx;
  logic [4:0]    w_lp_flags;
  logic          w_lp_rdfpu;

  logic          w_rf_ena;
  logic [31:0]   w_rf_wdat;
  logic [4:0]    w_rf_rdidx;
  logic          w_frf_ena;
  logic [31:0]   w_frf_wdat;
  logic [4:0]    w_frf_rdidx;
  logic [4:0]    w_frf_flags;

  assign w_lp_any         = |longp_wbck_i_valid;
  assign w_starve         = alu_wbck_i_valid && (r_starve_cnt == C_STARVE_MAX);
  assign w_lp_win         = w_lp_any && !w_starve;
  assign w_alu_gnt        = alu_wbck_i_valid && !w_lp_win;
  assign alu_wbck_i_ready = w_alu_gnt;

  // Scan from rr_ptr upward with wrap; walking the offsets downward lets the
  // nearest valid channel overwrite any farther one.
  always_comb begin : p_rr_sel
    int k;
    k        = 0;
    w_lp_sel = '0;
    for (int i = LP_CHNL - 1; i >= 0; i--) begin
      k = int'(r_rr_ptr) + i;
      if (k >= LP_CHNL) k = k - LP_CHNL;
      if (longp_wbck_i_valid[k]) w_lp_sel = PW'(k);
    end
  end

  always_comb begin : p_lp_mux
    w_lp_wdat          = '0;
    w_lp_rdidx         = '0;
    w_lp_flags         = '0;
    w_lp_rdfpu         = 1'b0;
    longp_wbck_i_ready = '0;
    for (int j = 0; j < LP_CHNL; j++) begin
      if (PW'(j) == w_lp_sel) begin
        w_lp_wdat             = longp_wbck_i_wdat[32*j +: 32];
        w_lp_rdidx            = longp_wbck_i_rdidx[5*j +: 5];
        w_lp_flags            = longp_wbck_i_flags[5*j +: 5];
        w_lp_rdfpu            = longp_wbck_i_rdfpu[j];
        longp_wbck_i_ready[j] = w_lp_win;
      end
    end
  end

  assign w_rf_ena    = w_alu_gnt || (w_lp_win && !w_lp_rdfpu);
  assign w_rf_wdat   = w_lp_win ? w_lp_wdat  : alu_wbck_i_wdat;
  assign w_rf_rdidx  = w_lp_win ? w_lp_rdidx : alu_wbck_i_rdidx;
  assign w_frf_ena   = w_lp_win && w_lp_rdfpu;
  assign w_frf_wdat  = w_lp_wdat;
  assign w_frf_rdidx = w_lp_rdidx;
  assign w_frf_flags = w_lp_flags;

  generate
    if (LP_CHNL > 1) begin : g_rr_ptr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rr_ptr <= '0;
        end else if (w_lp_win) begin
          r_rr_ptr <= (int'(w_lp_sel) == LP_CHNL - 1) ? '0 : w_lp_sel + PW'(1);
        end
      end
    end else begin : g_rr_fixed
      assign r_rr_ptr = '0;
    end
  endgenerate

  // Counts only while the ALU is actually waiting; a dropped request forgets its history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!alu_wbck_i_valid || w_alu_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != C_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic        r_rf_ena;
      logic [31:0] r_rf_wdat;
      logic [4:0]  r_rf_rdidx;
      logic        r_frf_ena;
      logic [31:0] r_frf_wdat;
      logic [4:0]  r_frf_rdidx;
      logic [4:0]  r_frf_flags;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rf_ena    <= 1'b0;
          r_rf_wdat   <= '0;
          r_rf_rdidx  <= '0;
          r_frf_ena   <= 1'b0;
          r_frf_wdat  <= '0;
          r_frf_rdidx <= '0;
          r_frf_flags <= '0;
        end else begin
          r_rf_ena  <= w_rf_ena;
          r_frf_ena <= w_frf_ena;
          if (w_rf_ena) begin
            r_rf_wdat  <= w_rf_wdat;
            r_rf_rdidx <= w_rf_rdidx;
          end
          if (w_frf_ena) begin
            r_frf_wdat  <= w_frf_wdat;
            r_frf_rdidx <= w_frf_rdidx;
            r_frf_flags <= w_frf_flags;
          end
        end
      end

      assign rf_wbck_o_ena    = r_rf_ena;
      assign rf_wbck_o_wdat   = r_rf_wdat;
      assign rf_wbck_o_rdidx  = r_rf_rdidx;
      assign frf_wbck_o_ena   = r_frf_ena;
      assign frf_wbck_o_wdat  = r_frf_wdat;
      assign frf_wbck_o_rdidx = r_frf_rdidx;
      assign frf_wbck_o_flags = r_frf_flags;
    end else begin : g_out_comb
      assign rf_wbck_o_ena    = w_rf_ena;
      assign rf_wbck_o_wdat   = w_rf_wdat;
      assign rf_wbck_o_rdidx  = w_rf_rdidx;
      assign frf_wbck_o_ena   = w_frf_ena;
      assign frf_wbck_o_wdat  = w_frf_wdat;
      assign frf_wbck_o_rdidx = w_frf_rdidx;
      assign frf_wbck_o_flags = w_frf_flags;
    end
  endgenerate

endmodule
`default_nettype wire
